// File: rtl/cmp_share_arbiter_if.sv
// Request/response bundle between requester blocks and the shared-comparator
// arbiter. The master side issues operand pairs and consumes responses; the
// slave side is the arbiter.
interface cmp_share_arbiter_if #(
    parameter int N    = 8,
    parameter int NREQ = 4
);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*N-1:0] req_a;
    logic [NREQ*N-1:0] req_b;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic              rsp_lt;
    logic              rsp_eq;
    logic              rsp_gt;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_lt, rsp_eq, rsp_gt
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_lt, rsp_eq, rsp_gt
    );
endinterface

// File: rtl/cmp_share_arbiter.sv
// Round-robin arbiter that time-shares one magnitude comparator among NREQ
// requesters. Each accepted request takes three states: grant (IDLE), one
// cycle for the comparator to settle on registered operands (SETTLE), and a
// held response until the consumer accepts it (RESP). A sticky error flags
// comparator outputs that were not exactly one-hot when captured.
module cmp_share_arbiter #(
    parameter int N    = 8,
    parameter int NREQ = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    cmp_share_arbiter_if.slave    bus,
    output logic [N-1:0]          cmp_a,
    output logic [N-1:0]          cmp_b,
    input  logic                  cmp_lt,
    input  logic                  cmp_eq,
    input  logic                  cmp_gt,
    output logic                  busy,
    output logic                  err
);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {IDLE, SETTLE, RESP} state_t;

    state_t         state_q, state_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [N-1:0]   cmp_a_q, cmp_a_d;
    logic [N-1:0]   cmp_b_q, cmp_b_d;
    logic           rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0] rsp_id_q, rsp_id_d;
    logic           rsp_lt_q, rsp_lt_d;
    logic           rsp_eq_q, rsp_eq_d;
    logic           rsp_gt_q, rsp_gt_d;
    logic           err_q, err_d;

    logic            grant_found;
    logic [IDW-1:0]  grant_idx;
    logic [NREQ-1:0] req_ready_c;
    logic [2:0]      flags;
    logic            flags_onehot;
    int              idx;

    // Round-robin search: first valid requester at or above ptr, wrapping.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        idx         = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!grant_found && bus.req_valid[idx[IDW-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = idx[IDW-1:0];
            end
        end
    end

    // Comparator flag sanity: a healthy comparator asserts exactly one flag.
    always_comb begin
        flags        = {cmp_lt, cmp_eq, cmp_gt};
        flags_onehot = (flags == 3'b100) || (flags == 3'b010) || (flags == 3'b001);
    end

    // FSM next-state, operand capture and response bookkeeping.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        cmp_a_d     = cmp_a_q;
        cmp_b_d     = cmp_b_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_lt_d    = rsp_lt_q;
        rsp_eq_d    = rsp_eq_q;
        rsp_gt_d    = rsp_gt_q;
        err_d       = err_q;
        req_ready_c = '0;
        case (state_q)
            IDLE: begin
                if (grant_found) begin
                    req_ready_c = NREQ'(1) << grant_idx;
                    cmp_a_d     = bus.req_a[grant_idx*N +: N];
                    cmp_b_d     = bus.req_b[grant_idx*N +: N];
                    rsp_id_d    = grant_idx;
                    ptr_d       = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
                    state_d     = SETTLE;
                end
            end
            SETTLE: begin
                rsp_lt_d    = cmp_lt;
                rsp_eq_d    = cmp_eq;
                rsp_gt_d    = cmp_gt;
                rsp_valid_d = 1'b1;
                if (!flags_onehot) err_d = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                // Returning to IDLE means the next grant is at least one
                // cycle after the response handshake.
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register; an asynchronous reset discards any in-flight request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            cmp_a_q     <= '0;
            cmp_b_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_lt_q    <= 1'b0;
            rsp_eq_q    <= 1'b0;
            rsp_gt_q    <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            cmp_a_q     <= cmp_a_d;
            cmp_b_q     <= cmp_b_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_lt_q    <= rsp_lt_d;
            rsp_eq_q    <= rsp_eq_d;
            rsp_gt_q    <= rsp_gt_d;
            err_q       <= err_d;
        end
    end

    // Grant is forced low while reset is asserted so nothing looks accepted.
    assign bus.req_ready = rst_n ? req_ready_c : '0;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_lt    = rsp_lt_q;
    assign bus.rsp_eq    = rsp_eq_q;
    assign bus.rsp_gt    = rsp_gt_q;
    assign cmp_a         = cmp_a_q;
    assign cmp_b         = cmp_b_q;
    assign busy          = (state_q != IDLE);
    assign err           = err_q;
endmodule

// File: tb/tb_cmp_share_arbiter.sv
// Bench for cmp_share_arbiter: directed requests with hand-computed results,
// a scoreboard queue filled at grant time and a monitor that pops on every
// response handshake.
module tb_cmp_share_arbiter;
    localparam int N    = 8;
    localparam int NREQ = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cmp_share_arbiter_if #(.N(N), .NREQ(NREQ)) bus ();

    logic [N-1:0] cmp_a, cmp_b;
    logic         cmp_lt, cmp_eq, cmp_gt;
    logic         busy, err;
    logic         force_bad;

    // Behavioural comparator; force_bad zeroes all flags to provoke err.
    assign cmp_lt = force_bad ? 1'b0 : (cmp_a <  cmp_b);
    assign cmp_eq = force_bad ? 1'b0 : (cmp_a == cmp_b);
    assign cmp_gt = force_bad ? 1'b0 : (cmp_a >  cmp_b);

    cmp_share_arbiter #(.N(N), .NREQ(NREQ)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus    (bus.slave),
        .cmp_a  (cmp_a),
        .cmp_b  (cmp_b),
        .cmp_lt (cmp_lt),
        .cmp_eq (cmp_eq),
        .cmp_gt (cmp_gt),
        .busy   (busy),
        .err    (err)
    );

    typedef struct packed {
        logic [1:0] id;
        logic       lt;
        logic       eq;
        logic       gt;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   gcyc, prev_gcyc, rr_id;
    logic [2:0] rr_exp [4];
    logic [4:0] snap;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_op(input int i, input logic [N-1:0] a, input logic [N-1:0] b);
        bus.req_a[i*N +: N] = a;
        bus.req_b[i*N +: N] = b;
    endtask

    task automatic push(input int id, input logic lt, input logic eq, input logic gt);
        exp_t e;
        e.id = 2'(id);
        e.lt = lt;
        e.eq = eq;
        e.gt = gt;
        sb.push_back(e);
    endtask

    // Wait (bounded) for a grant at a falling edge and compare it.
    task automatic wait_grant(input logic [NREQ-1:0] exp, input string name, output int gc);
        int n;
        n = 0;
        @(negedge clk);
        while (bus.req_ready == '0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check(name, bus.req_ready, exp);
        gc = cyc;
    endtask

    // Wait (bounded) until the arbiter is idle, then step to just after a rising edge.
    task automatic idle_sync();
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("idle_reached", busy, 1'b0);
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every response handshake must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && bus.rsp_valid && bus.rsp_ready) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL rsp_unexpected: got response id %0d, expected none", bus.rsp_id);
            end else begin
                mon_e = sb.pop_front();
                check("rsp_id", bus.rsp_id, mon_e.id);
                check("rsp_flags", {bus.rsp_lt, bus.rsp_eq, bus.rsp_gt}, {mon_e.lt, mon_e.eq, mon_e.gt});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        force_bad     = 1'b0;
        bus.rsp_ready = 1'b1;
        bus.req_valid = 4'b1111;
        bus.req_a     = '0;
        bus.req_b     = '0;
        set_op(0, 8'hFF, 8'hFF);
        set_op(1, 8'h00, 8'hFF);
        set_op(2, 8'h80, 8'h7F);
        set_op(3, 8'h10, 8'h03);
        rr_exp = '{3'b010, 3'b100, 3'b001, 3'b001};

        // Reset state, with all requesters already valid.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", bus.req_ready, 4'b0000);
        check("rst_rsp_valid", bus.rsp_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_cmp_ab", {cmp_a, cmp_b}, 16'h0000);
        check("rst_rsp_id", bus.rsp_id, 2'd0);

        // Round robin with all four valid: 0,1,2,3,0 spaced 3 cycles.
        @(posedge clk);
        #1 rst_n = 1'b1;
        prev_gcyc = 0;
        for (int g = 0; g < 5; g++) begin
            rr_id = g % 4;
            wait_grant(4'b0001 << rr_id, "rr_grant", gcyc);
            push(rr_id, rr_exp[rr_id][2], rr_exp[rr_id][1], rr_exp[rr_id][0]);
            if (g > 0) check("rr_spacing", gcyc - prev_gcyc, 3);
            prev_gcyc = gcyc;
        end
        @(posedge clk);
        #1 bus.req_valid = '0;
        idle_sync();

        // Single requester 2: 05 vs 09, latency and operand sampling.
        set_op(2, 8'h05, 8'h09);
        bus.req_valid = 4'b0100;
        wait_grant(4'b0100, "t1_grant", gcyc);
        check("t1_busy_grant", busy, 1'b0);
        push(2, 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #1 bus.req_valid = '0;
        set_op(2, 8'hAA, 8'hAA);
        @(negedge clk);
        check("t1_busy_settle", busy, 1'b1);
        check("t1_rsp_valid_settle", bus.rsp_valid, 1'b0);
        check("t1_cmp_ab", {cmp_a, cmp_b}, 16'h0509);
        check("t1_ready_settle", bus.req_ready, 4'b0000);
        @(negedge clk);
        check("t1_rsp_valid_t2", bus.rsp_valid, 1'b1);
        check("t1_cmp_ab_hold", {cmp_a, cmp_b}, 16'h0509);
        @(negedge clk);
        check("t1_rsp_valid_done", bus.rsp_valid, 1'b0);
        check("t1_busy_done", busy, 1'b0);
        idle_sync();

        // Back-pressure: response held while requester 1 waits.
        bus.rsp_ready = 1'b0;
        set_op(3, 8'h20, 8'h20);
        bus.req_valid = 4'b1000;
        wait_grant(4'b1000, "hold_grant", gcyc);
        push(3, 1'b0, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        set_op(1, 8'h33, 8'h44);
        bus.req_valid = 4'b0010;
        @(negedge clk);
        check("hold_ready_settle", bus.req_ready, 4'b0000);
        @(negedge clk);
        check("hold_rsp_valid", bus.rsp_valid, 1'b1);
        snap = {bus.rsp_id, bus.rsp_lt, bus.rsp_eq, bus.rsp_gt};
        check("hold_rsp_value", snap, 5'b11_010);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("hold_rsp_valid_stable", bus.rsp_valid, 1'b1);
            check("hold_rsp_stable", {bus.rsp_id, bus.rsp_lt, bus.rsp_eq, bus.rsp_gt}, snap);
            check("hold_req_ready", bus.req_ready, 4'b0000);
            check("hold_busy", busy, 1'b1);
        end
        @(posedge clk);
        #1 bus.rsp_ready = 1'b1;
        @(negedge clk);
        check("hold_no_grant_on_hs", bus.req_ready, 4'b0000);
        @(negedge clk);
        check("hold_grant_after_hs", bus.req_ready, 4'b0010);
        push(1, 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #1 bus.req_valid = '0;
        idle_sync();

        // Broken comparator for one request: err sets and sticks.
        set_op(0, 8'h01, 8'h02);
        bus.req_valid = 4'b0001;
        wait_grant(4'b0001, "err_grant", gcyc);
        check("err_before", err, 1'b0);
        force_bad = 1'b1;
        push(0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1 bus.req_valid = '0;
        @(negedge clk);
        @(negedge clk);
        check("err_set", err, 1'b1);
        idle_sync();
        force_bad = 1'b0;
        set_op(2, 8'h07, 8'h07);
        bus.req_valid = 4'b0100;
        wait_grant(4'b0100, "err_good_grant", gcyc);
        push(2, 1'b0, 1'b1, 1'b0);
        @(posedge clk);
        #1 bus.req_valid = '0;
        idle_sync();
        check("err_sticky", err, 1'b1);

        // Asynchronous reset during SETTLE aborts the request.
        set_op(1, 8'h09, 8'h01);
        bus.req_valid = 4'b0010;
        wait_grant(4'b0010, "abort_grant", gcyc);
        @(posedge clk);
        #1 bus.req_valid = '0;
        check("abort_in_settle", busy, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        check("abort_busy", busy, 1'b0);
        check("abort_rsp_valid", bus.rsp_valid, 1'b0);
        check("abort_cmp_ab", {cmp_a, cmp_b}, 16'h0000);
        check("abort_rsp_id", bus.rsp_id, 2'd0);
        check("abort_err", err, 1'b0);
        check("abort_req_ready", bus.req_ready, 4'b0000);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        set_op(0, 8'hC3, 8'h3C);
        set_op(3, 8'h01, 8'h01);
        bus.req_valid = 4'b1001;
        wait_grant(4'b0001, "post_reset_grant", gcyc);
        push(0, 1'b0, 1'b0, 1'b1);
        @(posedge clk);
        #1 bus.req_valid = '0;
        idle_sync();
        repeat (3) @(posedge clk);
        check("sb_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/cmp_share_arbiter.md
Name: cmp_share_arbiter

Overview:
- Shares one N-bit magnitude comparator (ports a, b, lt, eq, gt) among NREQ requesters.
- Requesters present operand pairs over a valid/ready handshake; round-robin arbitration selects one at a time.
- The block drives the comparator from registered operands, captures its flags, and returns a response tagged with the requester ID.
- Sits between requester blocks and the shared comparator instance; also flags non-one-hot comparator outputs.

Parameters:
- N, 8: operand width; must be ≥ 1.
- NREQ, 4: number of requesters; must be ≥ 2.
- IDW, $clog2(NREQ): response ID width; localparam, minimum 1.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester grant/accept; combinational, at most one bit high.
- req_a  in  NREQ*N  packed operand a; requester i uses bits [i*N +: N].
- req_b  in  NREQ*N  packed operand b; same packing as req_a.
- cmp_a  out  N  operand a to comparator; registered.
- cmp_b  out  N  operand b to comparator; registered.
- cmp_lt  in  1  comparator a<b (combinational from cmp_a/cmp_b).
- cmp_eq  in  1  comparator a==b.
- cmp_gt  in  1  comparator a>b.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumer ready.
- rsp_id  out  IDW  requester index of the response.
- rsp_lt  out  1  captured lt.
- rsp_eq  out  1  captured eq.
- rsp_gt  out  1  captured gt.
- busy  out  1  high whenever state != IDLE.
- err  out  1  sticky; set when captured flags are not exactly one-hot.

Behaviour:
- Reset (async, rst_n=0) clears:
  - state=IDLE; rr pointer=0.
  - cmp_a=0, cmp_b=0.
  - rsp_valid=0, rsp_id=0, rsp_lt/eq/gt=0.
  - busy=0, err=0; req_ready=0.
  - Any in-flight request is discarded; no response is produced for it.
- States: IDLE, SETTLE, RESP.
- IDLE:
  - If any req_valid is high, grant g = first set bit scanning upward from ptr, wrapping modulo NREQ.
  - req_ready[g]=1 combinationally in that cycle; that cycle is the handshake.
  - At the edge: cmp_a/cmp_b <= slice g; rsp_id <= g; ptr <= (g+1) mod NREQ; go to SETTLE.
  - req_ready is 0 in every other state.
- SETTLE (1 cycle):
  - Comparator settles on the registered operands.
  - At the edge: rsp_lt/eq/gt <= cmp_lt/eq/gt; rsp_valid <= 1; go to RESP.
  - If {cmp_lt,cmp_eq,cmp_gt} is not one-hot, err <= 1.
- RESP:
  - Hold rsp_* stable while rsp_ready=0.
  - On rsp_valid && rsp_ready: rsp_valid <= 0; go to IDLE.
  - No new grant is issued in the same cycle as the response handshake.
- Latency: grant at cycle T → rsp_valid first high at T+2. Minimum period is 3 cycles per request (grant, settle, response handshake).
- Fairness: after granting i, requester i has lowest priority next time. A requester holding valid waits at most NREQ-1 other grants.
- Requesters must hold req_valid and operands stable until req_ready. The block samples operands only in the grant cycle; later operand changes do not affect cmp_a/cmp_b.
- cmp_a/cmp_b hold their last values outside grants.
- req_valid with no grant (non-IDLE state) is ignored; nothing is queued.
- err clears only on reset.

Test Plan:
- Req 2 only, a=8'h05, b=8'h09 → req_ready=4'b0100 at T; rsp_valid at T+2 with rsp_id=2, lt=1, eq=0, gt=0; busy high T+1..response handshake.
- All four req_valid held high from reset, rsp_ready=1 → grants in order 0,1,2,3,0, spaced 3 cycles apart; ptr wraps 3→0.
- Boundary operands: a=b=8'hFF → eq=1; a=8'h00, b=8'hFF → lt=1; a=8'h80, b=8'h7F → gt=1 (unsigned).
- rsp_ready held low 5 cycles with req 1 valid pending → rsp_* stable throughout, req_ready stays 0, busy=1; req 1 is granted the cycle after the response handshake.
- Comparator model forced to lt=eq=gt=0 for one request → err=1, stays 1 through later good responses until reset.
- rst_n pulsed low while in SETTLE → all outputs at reset values immediately (async); no rsp_valid for the aborted request; next grant starts from requester 0.
